// File: rtl/voxel_raster_engine.sv
// voxel_raster_engine: renders an N^3 colour voxel grid as an orthographic
// projection (front/top/side/rear) into a framebuffer during vertical blank.
// Ports: clk, reset (async, active-high); display_on/hpos/vpos from the sync
// generator (hpos unused); view and bg_color sampled at pass start;
// vox_we/vox_addr{z,y,x}/vox_data voxel load port; we/addr/ram_d registered
// framebuffer write port; busy while a pass runs; done one-cycle pulse at
// the end of a completed pass.
// Option: define VOXEL_DEPTH_SHADE_EN to darken hits by depth (shift 0..3).
module voxel_raster_engine #(
  parameter int DIM_BITS       = 3,
  parameter int COLOR_W        = 8,
  parameter int ADDR_W         = 12,
  parameter int FB_STRIDE_BITS = 6,
  parameter int FB_BASE        = 0,
  parameter int START_LINE     = 240
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  display_on,
  input  logic [8:0]            hpos,
  input  logic [8:0]            vpos,
  input  logic [1:0]            view,
  input  logic [COLOR_W-1:0]    bg_color,
  input  logic                  vox_we,
  input  logic [3*DIM_BITS-1:0] vox_addr,
  input  logic [COLOR_W-1:0]    vox_data,
  output logic                  we,
  output logic [ADDR_W-1:0]     addr,
  output logic [COLOR_W-1:0]    ram_d,
  output logic                  busy,
  output logic                  done
);

  localparam int N  = 1 << DIM_BITS;
  localparam int VW = 3 * DIM_BITS;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CHECK,
    WRITE,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [DIM_BITS-1:0] u_q, u_d;
  logic [DIM_BITS-1:0] v_q, v_d;
  logic [DIM_BITS-1:0] d_q, d_d;
  logic [1:0]          view_q, view_d;
  logic [COLOR_W-1:0]  bg_q, bg_d;

  logic                we_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [COLOR_W-1:0]  pix_d;

  logic                disp_q;
  logic                trig_q;

  logic [COLOR_W-1:0]  mem [N*N*N];
  logic [COLOR_W-1:0]  rd_data;
  logic [VW-1:0]       rd_addr;

  logic [DIM_BITS-1:0] vx, vy, vz;
  logic [COLOR_W-1:0]  hit_color;
  logic [ADDR_W-1:0]   fb_addr;

  logic                unused_hpos;
  assign unused_hpos = ^hpos;

  // Voxel store: read-before-write on a same-address collision.
  always_ff @(posedge clk) begin
    if (vox_we) begin
      mem[vox_addr] <= vox_data;
    end
    rd_data <= mem[rd_addr];
  end

  // Map projected cell (u,v) and depth step d to grid coordinates.
  always_comb begin
    vx = u_q;
    vy = v_q;
    vz = d_q;
    unique case (view_q)
      2'd0: begin
        vx = u_q;
        vz = d_q;
      end
      2'd1: begin
        vy = d_q;
        vz = v_q;
      end
      2'd2: begin
        vx = d_q;
        vz = u_q;
      end
      2'd3: begin
        vx = ~u_q;
        vz = ~d_q;
      end
    endcase
  end

  assign rd_addr = {vz, vy, vx};

  assign fb_addr = ADDR_W'(FB_BASE)
                 + (ADDR_W'(v_q) << FB_STRIDE_BITS)
                 + ADDR_W'(u_q);

`ifdef VOXEL_DEPTH_SHADE_EN
  assign hit_color = rd_data >> d_q[DIM_BITS-1 -: 2];
`else
  assign hit_color = rd_data;
`endif

  always_comb begin
    state_d = state_q;
    u_d     = u_q;
    v_d     = v_q;
    d_d     = d_q;
    view_d  = view_q;
    bg_d    = bg_q;
    we_d    = 1'b0;
    addr_d  = addr;
    pix_d   = ram_d;
    unique case (state_q)
      IDLE: begin
        if (trig_q) begin
          state_d = READ;
          u_d     = '0;
          v_d     = '0;
          d_d     = '0;
          view_d  = view;
          bg_d    = bg_color;
        end
      end
      READ: begin
        state_d = CHECK;
      end
      CHECK: begin
        if (rd_data != '0) begin
          state_d = WRITE;
          we_d    = 1'b1;
          addr_d  = fb_addr;
          pix_d   = hit_color;
        end else if (&d_q) begin
          state_d = WRITE;
          we_d    = 1'b1;
          addr_d  = fb_addr;
          pix_d   = bg_q;
        end else begin
          d_d     = d_q + 1'b1;
          state_d = READ;
        end
      end
      WRITE: begin
        d_d = '0;
        u_d = u_q + 1'b1;
        if (&u_q) begin
          v_d = v_q + 1'b1;
        end
        if (&u_q && &v_q) begin
          state_d = DONE;
        end else begin
          state_d = READ;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Active video always wins: abandon the pass, no write, no done.
    if (display_on && state_q != IDLE) begin
      state_d = IDLE;
      we_d    = 1'b0;
      addr_d  = addr;
      pix_d   = ram_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      u_q     <= '0;
      v_q     <= '0;
      d_q     <= '0;
      view_q  <= '0;
      bg_q    <= '0;
      we      <= 1'b0;
      addr    <= '0;
      ram_d   <= '0;
      disp_q  <= 1'b0;
      trig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      u_q     <= u_d;
      v_q     <= v_d;
      d_q     <= d_d;
      view_q  <= view_d;
      bg_q    <= bg_d;
      we      <= we_d;
      addr    <= addr_d;
      ram_d   <= pix_d;
      disp_q  <= display_on;
      trig_q  <= disp_q & ~display_on
               & (vpos == 9'(START_LINE));
    end
  end

  assign busy = (state_q == READ)
              | (state_q == CHECK)
              | (state_q == WRITE);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_voxel_raster_engine.sv
// tb_voxel_raster_engine: directed bench with a projection model that
// predicts every framebuffer write and the busy length of each pass.
module tb_voxel_raster_engine;

  logic        clk;
  logic        reset;
  logic        display_on;
  logic [8:0]  hpos;
  logic [8:0]  vpos;
  logic [1:0]  view;
  logic [7:0]  bg_color;
  logic        vox_we;
  logic [8:0]  vox_addr;
  logic [7:0]  vox_data;
  logic        we;
  logic [11:0] addr;
  logic [7:0]  ram_d;
  logic        busy;
  logic        done;

  voxel_raster_engine dut (
    .clk        (clk),
    .reset      (reset),
    .display_on (display_on),
    .hpos       (hpos),
    .vpos       (vpos),
    .view       (view),
    .bg_color   (bg_color),
    .vox_we     (vox_we),
    .vox_addr   (vox_addr),
    .vox_data   (vox_data),
    .we         (we),
    .addr       (addr),
    .ram_d      (ram_d),
    .busy       (busy),
    .done       (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  int wr_cnt   = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  int exp_busy = 0;
  logic we_prev = 1'b0;

  int exp_a[$];
  int exp_d[$];
  logic [7:0] fb [4096];
  logic [7:0] mdl [8][8][8];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  // Projection model: scan v then u, nearest non-empty voxel wins.
  task automatic build(input int vw, input int bg, output int cyc);
    exp_a.delete();
    exp_d.delete();
    cyc = 0;
    for (int v = 0; v < 8; v++) begin
      for (int u = 0; u < 8; u++) begin
        int col;
        int hit;
        col = bg;
        hit = 0;
        for (int d = 0; d < 8; d++) begin
          int x;
          int y;
          int z;
          int c;
          x = u;
          y = v;
          z = d;
          if (vw == 1) begin
            y = d;
            z = v;
          end else if (vw == 2) begin
            x = d;
            z = u;
          end else if (vw == 3) begin
            x = 7 - u;
            z = 7 - d;
          end
          c = int'(mdl[x][y][z]);
          if (hit == 0 && c != 0) begin
            hit = 1;
`ifdef VOXEL_DEPTH_SHADE_EN
            col = c >> (d >> 1);
`else
            col = c;
`endif
            cyc += 2 * (d + 1) + 1;
          end
        end
        if (hit == 0) begin
          cyc += 17;
        end
        exp_a.push_back(v * 64 + u);
        exp_d.push_back(col);
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      we_prev = 1'b0;
    end else begin
      if (we) begin
        chk("we_gap", int'(we_prev), 0);
        if (exp_a.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_write actual=0x%0h required=none",
                   int'(addr));
        end else begin
          chk("wr_addr", int'(addr), exp_a.pop_front());
          chk("wr_data", int'(ram_d), exp_d.pop_front());
        end
        fb[addr] = ram_d;
        wr_cnt++;
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        chk("done_busy", int'(busy), 0);
      end
      we_prev = we;
    end
  end

  task automatic vox_write(input int x, input int y, input int z,
                           input logic [7:0] c);
    vox_addr = 9'((z << 6) | (y << 3) | x);
    vox_data = c;
    vox_we   = 1'b1;
    @(posedge clk);
    #1;
    vox_we = 1'b0;
    mdl[x][y][z] = c;
  endtask

  task automatic trigger(input int vw, input logic [7:0] bg,
                         input int line);
    int eb;
    for (int i = 0; i < 4096; i++) fb[i] = 8'hAA;
    build(vw, int'(bg), eb);
    exp_busy   = eb;
    wr_cnt     = 0;
    busy_cnt   = 0;
    done_cnt   = 0;
    view       = 2'(vw);
    bg_color   = bg;
    display_on = 1'b1;
    vpos       = 9'(line - 1);
    repeat (3) @(posedge clk);
    #1;
    vpos       = 9'(line);
    display_on = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("busy_pre", int'(busy), 0);
    @(negedge clk);
    chk("busy_rise", int'(busy), (line == 240) ? 1 : 0);
  endtask

  task automatic finish_pass(input string nm);
    int to;
    to = 1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt != 0) begin
        to = 0;
        break;
      end
    end
    chk({nm, "_timeout"}, to, 0);
    repeat (3) @(negedge clk);
    #1;
    chk({nm, "_writes"}, wr_cnt, 64);
    chk({nm, "_done"}, done_cnt, 1);
    chk({nm, "_busy"}, busy_cnt, exp_busy);
    chk({nm, "_left"}, exp_a.size(), 0);
    @(posedge clk);
    #1;
    display_on = 1'b1;
    vpos       = 9'd0;
  endtask

  initial begin
    int to;
    reset      = 1'b1;
    display_on = 1'b1;
    hpos       = 9'd0;
    vpos       = 9'd0;
    view       = 2'd0;
    bg_color   = 8'h00;
    vox_we     = 1'b0;
    vox_addr   = 9'd0;
    vox_data   = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we", int'(we), 0);
    chk("rst_addr", int'(addr), 0);
    chk("rst_ram_d", int'(ram_d), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int x = 0; x < 8; x++)
      for (int y = 0; y < 8; y++)
        for (int z = 0; z < 8; z++)
          vox_write(x, y, z, 8'h00);

    trigger(0, 8'h00, 240);
    finish_pass("empty");
    chk("empty_busy_lit", busy_cnt, 1088);
    chk("empty_fb0", int'(fb[0]), 0);
    chk("empty_fb455", int'(fb[455]), 0);
    chk("empty_fb8", int'(fb[8]), 8'hAA);

    vox_write(2, 3, 5, 8'h1C);
    trigger(0, 8'h40, 240);
    finish_pass("single");
`ifdef VOXEL_DEPTH_SHADE_EN
    chk("single_194", int'(fb[194]), 8'h07);
`else
    chk("single_194", int'(fb[194]), 8'h1C);
`endif
    chk("single_bg", int'(fb[0]), 8'h40);
    chk("single_busy_lit", busy_cnt, 63 * 17 + 13);

    vox_write(1, 1, 1, 8'hE0);
    vox_write(1, 1, 6, 8'h03);
    trigger(0, 8'h00, 240);
    finish_pass("front");
    chk("front_65", int'(fb[65]), 8'hE0);
    trigger(3, 8'h00, 240);
    finish_pass("rear");
    chk("rear_70", int'(fb[70]), 8'h03);

    vox_write(4, 0, 2, 8'hFF);
    trigger(1, 8'h05, 240);
    finish_pass("top");
    chk("top_132", int'(fb[132]), 8'hFF);

    trigger(0, 8'h00, 100);
    repeat (200) @(negedge clk);
    #1;
    chk("line100_writes", wr_cnt, 0);
    chk("line100_busy", busy_cnt, 0);
    chk("line100_done", done_cnt, 0);
    display_on = 1'b1;

    trigger(2, 8'h11, 240);
    to = 1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      #1;
      if (wr_cnt >= 10) begin
        to = 0;
        break;
      end
    end
    chk("abort_wait", to, 0);
    display_on = 1'b1;
    @(negedge clk);
    chk("abort_we", int'(we), 0);
    chk("abort_busy", int'(busy), 0);
    repeat (100) @(negedge clk);
    #1;
    chk("abort_writes", wr_cnt, 10);
    chk("abort_done", done_cnt, 0);

    trigger(2, 8'h11, 240);
    finish_pass("post_abort");

    trigger(0, 8'h22, 240);
    to = 1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      #1;
      if (we && wr_cnt >= 5) begin
        to = 0;
        break;
      end
    end
    chk("rst_wait", to, 0);
    reset = 1'b1;
    #1;
    chk("midrst_we", int'(we), 0);
    chk("midrst_addr", int'(addr), 0);
    chk("midrst_ram_d", int'(ram_d), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    @(posedge clk);
    #1;
    reset      = 1'b0;
    display_on = 1'b1;

    trigger(0, 8'h22, 240);
    finish_pass("post_rst");
`ifdef VOXEL_DEPTH_SHADE_EN
    chk("post_rst_194", int'(fb[194]), 8'h07);
`else
    chk("post_rst_194", int'(fb[194]), 8'h1C);
`endif
    chk("post_rst_65", int'(fb[65]), 8'hE0);
    chk("post_rst_bg", int'(fb[7]), 8'h22);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
